// File: rtl/m_lsu_pkg.sv
// rtl/m_lsu_pkg.sv - access-size encodings, FSM states and lane helpers for the M-stage LSU
package m_lsu_pkg;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
      return ((size == SIZE_H) && lo[0]) || ((size == SIZE_W) && (lo != 2'b00));
   endfunction

   function automatic logic [3:0] lane_byteen(input logic [1:0] size, input logic [1:0] lo);
      case (size)
         SIZE_B:  return 4'b0001 << lo;
         SIZE_H:  return lo[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] data);
      case (size)
         SIZE_B:  return {4{data[7:0]}};
         SIZE_H:  return {2{data[15:0]}};
         default: return data;
      endcase
   endfunction

endpackage

// File: rtl/m_load_ext.sv
// rtl/m_load_ext.sv - selects the addressed byte/half of a read word and sign/zero-extends it
module m_load_ext
   import m_lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        sign,
   output logic [31:0] ext
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = rdata[{addr_lo, 3'b000} +: 8];
      half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      case (size)
         SIZE_B:  ext = {{24{sign & byte_v[7]}}, byte_v};
         SIZE_H:  ext = {{16{sign & half_v[15]}}, half_v};
         default: ext = rdata;
      endcase
   end

endmodule

// File: rtl/m_lsu.sv
// rtl/m_lsu.sv - M-stage load/store unit: req/ack bus master that stalls the pipeline per access
module m_lsu
   import m_lsu_pkg::*;
#(
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        M_mem_read,
   input  logic        M_mem_write,
   input  logic [1:0]  M_mem_size,
   input  logic        M_mem_sign,
   input  logic [31:0] M_addr,
   input  logic [31:0] M_store_data,
   output logic        M_stall_req,
   output logic [31:0] M_MEM_read_data,
   output logic        M_align_err,
   output logic        M_bus_err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_byteen,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   logic [1:0]  state;
   logic [7:0]  cnt;
   logic [1:0]  lo_q;
   logic [1:0]  size_q;
   logic        sign_q;
   logic [31:0] result_q;
   logic        berr_q;
   logic [31:0] ext_data;
   logic        access;
   logic        misaligned;
   logic        go;

   assign access     = M_mem_read | M_mem_write;
   assign misaligned = is_misaligned(M_mem_size, M_addr[1:0]);
   assign go         = access & ~misaligned;

   assign M_align_err     = access & misaligned;
   assign M_stall_req     = ((state == ST_IDLE) & go) | (state == ST_REQ);
   assign M_MEM_read_data = (state == ST_DONE) ? result_q : 32'd0;
   assign M_bus_err       = (state == ST_DONE) & berr_q;

   m_load_ext u_load_ext (
      .rdata   (bus_rdata),
      .addr_lo (lo_q),
      .size    (size_q),
      .sign    (sign_q),
      .ext     (ext_data)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         cnt        <= 8'd0;
         bus_req    <= 1'b0;
         bus_we     <= 1'b0;
         bus_addr   <= 32'd0;
         bus_byteen <= 4'd0;
         bus_wdata  <= 32'd0;
         lo_q       <= 2'd0;
         size_q     <= 2'd0;
         sign_q     <= 1'b0;
         result_q   <= 32'd0;
         berr_q     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (go) begin
                  bus_req    <= 1'b1;
                  bus_we     <= M_mem_write;
                  bus_addr   <= {M_addr[31:2], 2'b00};
                  bus_byteen <= lane_byteen(M_mem_size, M_addr[1:0]);
                  bus_wdata  <= lane_wdata(M_mem_size, M_store_data);
                  lo_q       <= M_addr[1:0];
                  size_q     <= M_mem_size;
                  sign_q     <= M_mem_sign;
                  cnt        <= 8'd0;
                  result_q   <= 32'd0;
                  berr_q     <= 1'b0;
                  state      <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (bus_ack) begin
                  result_q <= bus_we ? 32'd0 : ext_data;
                  bus_req  <= 1'b0;
                  state    <= ST_DONE;
               end else if (cnt == 8'(TIMEOUT - 1)) begin
                  // Abort: the instruction retires with a zero result and the error flag.
                  berr_q   <= 1'b1;
                  result_q <= 32'd0;
                  bus_req  <= 1'b0;
                  state    <= ST_DONE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_m_lsu.sv
// tb/tb_m_lsu.sv - randomized and directed self-checking bench for m_lsu against a behavioural model
module tb_m_lsu;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        M_mem_read, M_mem_write, M_mem_sign;
   logic [1:0]  M_mem_size;
   logic [31:0] M_addr, M_store_data;
   logic        M_stall_req, M_align_err, M_bus_err;
   logic [31:0] M_MEM_read_data;
   logic        bus_req, bus_we, bus_ack;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_byteen;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   m_lsu #(.TIMEOUT(TO)) dut (
      .clk             (clk),
      .reset           (reset),
      .M_mem_read      (M_mem_read),
      .M_mem_write     (M_mem_write),
      .M_mem_size      (M_mem_size),
      .M_mem_sign      (M_mem_sign),
      .M_addr          (M_addr),
      .M_store_data    (M_store_data),
      .M_stall_req     (M_stall_req),
      .M_MEM_read_data (M_MEM_read_data),
      .M_align_err     (M_align_err),
      .M_bus_err       (M_bus_err),
      .bus_req         (bus_req),
      .bus_we          (bus_we),
      .bus_addr        (bus_addr),
      .bus_byteen      (bus_byteen),
      .bus_wdata       (bus_wdata),
      .bus_ack         (bus_ack),
      .bus_rdata       (bus_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit m_misal(input int size, input logic [31:0] addr);
      if (size == 1) return (addr % 2) != 0;
      if (size == 2) return (addr % 4) != 0;
      return 1'b0;
   endfunction

   function automatic logic [3:0] m_be(input int size, input logic [31:0] addr);
      if (size == 0) return 4'(1 << (addr % 4));
      if (size == 1) return 4'(3 << (addr % 4));
      return 4'hF;
   endfunction

   function automatic logic [31:0] m_wd(input int size, input logic [31:0] sd);
      if (size == 0) return (sd % 256) * 32'h01010101;
      if (size == 1) return (sd % 65536) * 32'h00010001;
      return sd;
   endfunction

   function automatic logic [31:0] m_ld(input int size, input bit sgn, input logic [31:0] addr,
                                        input logic [31:0] rd);
      int          bits;
      logic [31:0] v;
      if (size == 2) return rd;
      bits = (size == 0) ? 8 : 16;
      v = (rd >> (8 * (addr % 4))) % (32'd1 << bits);
      if (sgn && v >= (32'd1 << (bits - 1))) v = v - (32'd1 << bits);
      return v;
   endfunction

   task automatic idle_inputs();
      M_mem_read = 0; M_mem_write = 0; M_mem_size = 0; M_mem_sign = 0;
      M_addr = 0; M_store_data = 0; bus_ack = 0; bus_rdata = 0;
   endtask

   // Starts and ends one clock edge + 1 time unit into a cycle with the M inputs idle.
   task automatic do_access(input string tag, input bit wr, input int size, input bit sgn,
                            input logic [31:0] addr, input logic [31:0] sd,
                            input logic [31:0] rd, input int ack_delay);
      int reqs = 0, stalls = 0, exp_reqs;
      bit done = 0;
      M_mem_read = !wr; M_mem_write = wr; M_mem_size = 2'(size); M_mem_sign = sgn;
      M_addr = addr; M_store_data = sd;
      if (m_misal(size, addr)) begin
         @(negedge clk);
         chk({tag, ".align_err"}, 32'(M_align_err), 1);
         chk({tag, ".mis_stall"}, 32'(M_stall_req), 0);
         chk({tag, ".mis_rdata"}, M_MEM_read_data, 0);
         @(posedge clk); #1;
         chk({tag, ".mis_req"}, 32'(bus_req), 0);
         idle_inputs();
         return;
      end
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         bus_ack = 0; bus_rdata = $urandom;
         if (bus_req) begin
            if (reqs == 0) begin
               chk({tag, ".addr"}, bus_addr, addr & 32'hFFFF_FFFC);
               chk({tag, ".we"}, 32'(bus_we), 32'(wr));
               chk({tag, ".byteen"}, 32'(bus_byteen), 32'(m_be(size, addr)));
               if (wr) chk({tag, ".wdata"}, bus_wdata, m_wd(size, sd));
            end
            if (reqs == ack_delay) begin bus_ack = 1; bus_rdata = rd; end
            reqs++;
         end
         @(negedge clk);
         if (M_stall_req) stalls++; else done = 1;
         if (!done) begin @(posedge clk); #1; end
      end
      exp_reqs = (ack_delay < TO) ? ack_delay + 1 : TO;
      chk({tag, ".finished"}, 32'(done), 1);
      chk({tag, ".stalls"}, stalls, 1 + exp_reqs);
      chk({tag, ".reqs"}, reqs, exp_reqs);
      chk({tag, ".bus_err"}, 32'(M_bus_err), 32'(ack_delay >= TO));
      chk({tag, ".rdata"}, M_MEM_read_data,
          (ack_delay >= TO || wr) ? 32'd0 : m_ld(size, sgn, addr, rd));
      chk({tag, ".align_ok"}, 32'(M_align_err), 0);
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      chk({tag, ".idle_rdata"}, M_MEM_read_data, 0);
      chk({tag, ".idle_berr"}, 32'(M_bus_err), 0);
      chk({tag, ".idle_req"}, 32'(bus_req), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      int size;
      bit wr;
      logic [31:0] a;
      idle_inputs();
      reset = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst.req", 32'(bus_req), 0);
      chk("rst.we", 32'(bus_we), 0);
      chk("rst.addr", bus_addr, 0);
      chk("rst.byteen", 32'(bus_byteen), 0);
      chk("rst.wdata", bus_wdata, 0);
      chk("rst.rdata", M_MEM_read_data, 0);
      chk("rst.berr", 32'(M_bus_err), 0);
      chk("rst.stall", 32'(M_stall_req), 0);
      @(posedge clk); #1;
      reset = 1;
      @(posedge clk); #1;

      do_access("lw100", 0, 2, 0, 32'h100, 0, 32'h12345678, 0);
      do_access("lb203", 0, 0, 1, 32'h203, 0, 32'h80FFFFFF, 0);
      do_access("lbu203", 0, 0, 0, 32'h203, 0, 32'h80FFFFFF, 0);
      do_access("sh32", 1, 1, 0, 32'h32, 32'hAAAABEEF, 0, 3);
      do_access("lw102", 0, 2, 0, 32'h102, 0, 0, 0);
      do_access("lw_to", 0, 2, 0, 32'h40, 0, 32'hDEADBEEF, 99);
      do_access("lh_last", 0, 1, 1, 32'h46, 0, 32'h9ABC0000, TO - 1);

      // Reset pulled during REQ: bus_req must fall without waiting for a clock edge.
      M_mem_read = 1; M_mem_size = 2; M_addr = 32'h80;
      @(posedge clk); #1;
      chk("rstmid.req_before", 32'(bus_req), 1);
      #2 reset = 0;
      #1 chk("rstmid.req_after", 32'(bus_req), 0);
      chk("rstmid.rdata", M_MEM_read_data, 0);
      idle_inputs();
      @(posedge clk); #1;
      reset = 1;
      @(posedge clk); #1;
      do_access("rstmid.lw", 0, 2, 0, 32'h84, 0, 32'hCAFEF00D, 1);

      for (int i = 0; i < 40; i++) begin
         size = $urandom_range(0, 2);
         wr = $urandom_range(0, 1);
         a = $urandom;
         if ($urandom_range(0, 4) != 0) a = a & ~32'((size == 2) ? 3 : size);
         do_access($sformatf("rnd%0d", i), wr, size, 1'($urandom_range(0, 1)), a, $urandom,
                   $urandom, $urandom_range(0, 5));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
